multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback phases per instruction.
- Drives every datapath enable and mux select.
- Supplies the 6-bit opcode-style `o_aluOp` consumed by the ALU-control decoder.
- Handles variable-latency memory through a ready handshake with timeout.

---
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback and drives every datapath enable and mux select.
module multicycle_control #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [5:0] i_opcode,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic       o_pcWrite,
   output logic [1:0] o_pcSrc,
   output logic       o_iorD,
   output logic       o_memRead,
   output logic       o_memWrite,
   output logic       o_irWrite,
   output logic       o_regDst,
   output logic       o_memToReg,
   output logic       o_regWrite,
   output logic       o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [5:0] o_aluOp,
   output logic [3:0] o_state,
   output logic       o_illegal,
   output logic       o_memErr
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_R_WB      = 4'd4,
      S_EXEC_I    = 4'd5,
      S_I_WB      = 4'd6,
      S_MEM_ADDR  = 4'd7,
      S_MEM_READ  = 4'd8,
      S_MEM_WB    = 4'd9,
      S_MEM_WRITE = 4'd10,
      S_BRANCH    = 4'd11,
      S_JUMP      = 4'd12
   } state_t;

   localparam logic [5:0] OP_ADD = 6'h08;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [5:0]       op_reg, op_next;
   logic             timeout;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         op_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         op_reg    <= op_next;
      end
   end

   // A ready in the same cycle the counter hits WAIT_MAX still counts as success.
   assign timeout = !i_mem_ready && (cnt_reg == CNT_W'(WAIT_MAX));
   assign o_state = state_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = '0;
      op_next    = op_reg;
      o_pcWrite  = 1'b0;
      o_pcSrc    = 2'd0;
      o_iorD     = 1'b0;
      o_memRead  = 1'b0;
      o_memWrite = 1'b0;
      o_irWrite  = 1'b0;
      o_regDst   = 1'b0;
      o_memToReg = 1'b0;
      o_regWrite = 1'b0;
      o_aluSrcA  = 1'b0;
      o_aluSrcB  = 2'd0;
      o_aluOp    = 6'h00;
      o_illegal  = 1'b0;
      o_memErr   = 1'b0;
      case (state_reg)
         S_IDLE: state_next = S_FETCH;
         S_FETCH: begin
            o_memRead = 1'b1;
            o_aluSrcB = 2'd1;
            o_aluOp   = OP_ADD;
            if (i_mem_ready) begin
               o_irWrite  = 1'b1;
               o_pcWrite  = 1'b1;
               state_next = S_DECODE;
            end else if (timeout) begin
               // PC untouched, so staying here retries the same fetch.
               o_memErr   = 1'b1;
               state_next = S_FETCH;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_DECODE: begin
            op_next   = i_opcode;
            o_aluSrcB = 2'd3;
            o_aluOp   = OP_ADD;
            case (i_opcode)
               6'h00:               state_next = S_EXEC_R;
               6'h08, 6'h09, 6'h0F: state_next = S_EXEC_I;
               6'h23, 6'h2B:        state_next = S_MEM_ADDR;
               6'h04, 6'h05:        state_next = S_BRANCH;
               6'h02:               state_next = S_JUMP;
               default: begin
                  o_illegal  = 1'b1;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            o_aluSrcA  = 1'b1;
            o_aluSrcB  = 2'd0;
            o_aluOp    = 6'h00;
            state_next = S_R_WB;
         end
         S_R_WB: begin
            o_regDst   = 1'b1;
            o_regWrite = 1'b1;
            state_next = S_FETCH;
         end
         S_EXEC_I: begin
            o_aluSrcA  = 1'b1;
            o_aluSrcB  = 2'd2;
            o_aluOp    = op_reg;
            state_next = S_I_WB;
         end
         S_I_WB: begin
            o_regWrite = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_ADDR: begin
            o_aluSrcA  = 1'b1;
            o_aluSrcB  = 2'd2;
            o_aluOp    = op_reg;
            state_next = (op_reg == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            o_memRead = 1'b1;
            o_iorD    = 1'b1;
            if (i_mem_ready) begin
               state_next = S_MEM_WB;
            end else if (timeout) begin
               o_memErr   = 1'b1;
               state_next = S_FETCH;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_MEM_WB: begin
            o_memToReg = 1'b1;
            o_regWrite = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WRITE: begin
            o_memWrite = 1'b1;
            o_iorD     = 1'b1;
            if (i_mem_ready) begin
               state_next = S_FETCH;
            end else if (timeout) begin
               o_memErr   = 1'b1;
               state_next = S_FETCH;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_BRANCH: begin
            o_aluSrcA  = 1'b1;
            o_aluSrcB  = 2'd0;
            o_aluOp    = op_reg;
            o_pcSrc    = 2'd1;
            o_pcWrite  = ((op_reg == 6'h04) && i_zero) || ((op_reg == 6'h05) && !i_zero);
            state_next = S_FETCH;
         end
         S_JUMP: begin
            o_pcSrc    = 2'd2;
            o_pcWrite  = 1'b1;
            state_next = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded from its phase list into an
// expected per-cycle trace (state + control word), then replayed against the DUT.
module tb_multicycle_control;
   localparam int WAIT_MAX = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
   logic       alu_src_a, illegal, mem_err;
   logic [1:0] pc_src, alu_src_b;
   logic [5:0] alu_op;
   logic [3:0] state;

   int n_assert = 0;
   int n_fail   = 0;

   multicycle_control #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero),
      .i_mem_ready(mem_ready), .o_pcWrite(pc_write), .o_pcSrc(pc_src), .o_iorD(iord),
      .o_memRead(mem_read), .o_memWrite(mem_write), .o_irWrite(ir_write),
      .o_regDst(reg_dst), .o_memToReg(mem_to_reg), .o_regWrite(reg_write),
      .o_aluSrcA(alu_src_a), .o_aluSrcB(alu_src_b), .o_aluOp(alu_op), .o_state(state),
      .o_illegal(illegal), .o_memErr(mem_err)
   );

   always #5 clk = ~clk;

   logic [20:0] dut_cw;
   assign dut_cw = {pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal, mem_err};

   typedef struct packed {
      logic [3:0]  st;
      logic [20:0] cw;
      logic        rdy;
      logic        zr;
      logic [5:0]  opc;
   } step_t;

   step_t plan_q[$];
   logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h09, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};

   function automatic logic [20:0] cw(input logic pcw, input logic [1:0] pcs,
         input logic io, input logic mr, input logic mw, input logic irw, input logic rdst,
         input logic m2r, input logic rw, input logic asa, input logic [1:0] asb,
         input logic [5:0] aop, input logic ill, input logic merr);
      return {pcw, pcs, io, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, ill, merr};
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic [3:0] st, input logic [20:0] c, input logic rdy,
                       input logic zr, input logic [5:0] opc);
      step_t s;
      s.st = st; s.cw = c; s.rdy = rdy; s.zr = zr; s.opc = opc;
      plan_q.push_back(s);
   endtask

   // Non-memory phase: ready, zero and opcode are don't-cares, so randomise them.
   task automatic pushr(input logic [3:0] st, input logic [20:0] c);
      push(st, c, rbit(), rbit(), 6'($urandom));
   endtask

   // Control word of a memory phase cycle: ok = access completes, err = timeout abort.
   function automatic logic [20:0] mem_cw(input logic [3:0] st, input logic ok, input logic err);
      if (st == 4'd1)      return cw(ok, 2'd0, 0, 1, 0, ok, 0, 0, 0, 0, 2'd1, 6'h08, 0, err);
      else if (st == 4'd8) return cw(0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 6'h00, 0, err);
      else                 return cw(0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 6'h00, 0, err);
   endfunction

   // Memory access that is not ready for `waits` cycles; more than WAIT_MAX waits aborts.
   task automatic mem_phase(input logic [3:0] st, input int waits, output bit ok);
      bit done;
      done = 0;
      ok   = 0;
      for (int k = 0; k <= WAIT_MAX && !done; k++) begin
         if (k < waits) begin
            push(st, mem_cw(st, 0, k == WAIT_MAX), 1'b0, rbit(), 6'($urandom));
            if (k == WAIT_MAX) done = 1;
         end else begin
            push(st, mem_cw(st, 1, 0), 1'b1, rbit(), 6'($urandom));
            ok   = 1;
            done = 1;
         end
      end
   endtask

   // zmode: 0/1 forces the zero flag in the branch cycle, anything else randomises it.
   task automatic plan_instr(input logic [5:0] op, input int wf, input int wm, input int zmode);
      bit ok;
      bit legal;
      logic z;
      mem_phase(4'd1, wf, ok);
      if (!ok) return;
      legal = op inside {6'h00, 6'h08, 6'h09, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
      push(4'd2, cw(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 6'h08, !legal, 0), rbit(), rbit(), op);
      if (!legal) return;
      if (op == 6'h00) begin
         pushr(4'd3, cw(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 6'h00, 0, 0));
         pushr(4'd4, cw(0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 6'h00, 0, 0));
      end else if (op inside {6'h08, 6'h09, 6'h0F}) begin
         pushr(4'd5, cw(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, op, 0, 0));
         pushr(4'd6, cw(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 6'h00, 0, 0));
      end else if (op inside {6'h23, 6'h2B}) begin
         pushr(4'd7, cw(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, op, 0, 0));
         if (op == 6'h23) begin
            mem_phase(4'd8, wm, ok);
            if (ok) pushr(4'd9, cw(0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 6'h00, 0, 0));
         end else begin
            mem_phase(4'd10, wm, ok);
         end
      end else if (op inside {6'h04, 6'h05}) begin
         z = (zmode == 0) ? 1'b0 : (zmode == 1) ? 1'b1 : rbit();
         push(4'd11, cw((op == 6'h04) ? z : !z, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, op, 0, 0),
              rbit(), z, 6'($urandom));
      end else begin
         pushr(4'd12, cw(1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 6'h00, 0, 0));
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s at %0t: observed %h expected %h", tag, $time, got, exp);
      end
   endtask

   // One cycle: starts 1 time unit after a rising edge, checks 2 units later.
   task automatic exec_step(input step_t s);
      mem_ready = s.rdy;
      zero      = s.zr;
      opcode    = s.opc;
      #2;
      chk("state", 32'(state), 32'(s.st));
      chk($sformatf("ctl(st%0d)", s.st), 32'(dut_cw), 32'(s.cw));
      @(posedge clk);
      #1;
   endtask

   task automatic run_plan();
      while (plan_q.size() > 0) exec_step(plan_q.pop_front());
   endtask

   function automatic int rand_wait();
      if ($urandom_range(0, 7) < 6) return int'($urandom_range(0, 3));
      return $urandom_range(0, 1) ? WAIT_MAX : WAIT_MAX + 3;
   endfunction

   initial begin
      step_t s;
      rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
      #12;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_ctl", 32'(dut_cw), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      s.st = 4'd0; s.cw = '0; s.rdy = 1'b1; s.zr = 1'b0; s.opc = 6'h00;
      exec_step(s);

      // Directed: R-type, LW with two waits, BEQ taken, BNE not taken, illegal, SW stuck.
      plan_instr(6'h00, 0, 0, 2);
      plan_instr(6'h23, 0, 2, 2);
      plan_instr(6'h04, 0, 0, 1);
      plan_instr(6'h05, 0, 0, 1);
      plan_instr(6'h3F, 0, 0, 2);
      plan_instr(6'h2B, 0, 100, 2);
      plan_instr(6'h02, WAIT_MAX, 0, 2);
      plan_instr(6'h09, WAIT_MAX + 1, 0, 2);
      run_plan();

      for (int i = 0; i < 80; i++) begin
         logic [5:0] op;
         int sel;
         sel = int'($urandom_range(0, 10));
         op  = (sel == 10) ? 6'($urandom) : ops[sel];
         plan_instr(op, rand_wait(), rand_wait(), 2);
         run_plan();
      end

      // Reset asserted mid-MEM_WB must clear outputs without waiting for a clock edge.
      plan_instr(6'h23, 0, 0, 2);
      while (plan_q.size() > 1) exec_step(plan_q.pop_front());
      s = plan_q.pop_front();
      mem_ready = s.rdy; zero = s.zr; opcode = s.opc;
      #2;
      chk("memwb_state", 32'(state), 32'd9);
      chk("memwb_ctl", 32'(dut_cw), 32'(s.cw));
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_ctl", 32'(dut_cw), 32'd0);
      @(posedge clk);
      #1;
      chk("held_rst_state", 32'(state), 32'd0);
      #1 rst_n = 1'b1;
      #1;
      chk("post_rst_idle", 32'(state), 32'd0);
      chk("post_rst_ctl", 32'(dut_cw), 32'd0);
      @(posedge clk);
      #1;
      chk("post_rst_fetch", 32'(state), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
